// File: rtl/fifo_burst_reader_pkg.sv
// Shared constants for fifo_burst_reader: FSM state encodings, occupancy width helper and
// default burst/timeout settings.
package fifo_burst_reader_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int unsigned DEFAULT_BURST_LEN = 4;
  localparam int unsigned DEFAULT_TIMEOUT   = 15;

  // One extra bit so a completely full FIFO (count wrapped to 0) is representable.
  function automatic int unsigned cnt_eff_bit(input int unsigned data_depth);
    return data_depth + 1;
  endfunction

endpackage

// File: rtl/fifo_burst_reader.sv
// Drains a show-ahead FIFO read port into fixed-length, address-incrementing cache bursts.
// Optional partial-burst flush on idle timeout is enabled by BURST_READER_FLUSH_EN.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int unsigned DATA_BIT   = 16,
  parameter int unsigned DATA_DEPTH = 4,
  parameter int unsigned BURST_LEN  = DEFAULT_BURST_LEN,
  parameter int unsigned ADDR_BIT   = 8,
  parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_BIT-1:0]   fifo_data,
  input  logic                  fifo_empty,
  input  logic [DATA_DEPTH-1:0] fifo_cnt,
  output logic                  fifo_rd_en,
  output logic                  cache_valid,
  input  logic                  cache_ready,
  output logic [DATA_BIT-1:0]   cache_data,
  output logic [ADDR_BIT-1:0]   cache_addr,
  output logic                  cache_last,
  output logic                  burst_done,
  output logic                  busy
);

  localparam int unsigned CNT_BIT = cnt_eff_bit(DATA_DEPTH);
  localparam logic [CNT_BIT-1:0] FULL_CNT  = CNT_BIT'(1 << DATA_DEPTH);
  localparam logic [CNT_BIT-1:0] BURST_CNT = CNT_BIT'(BURST_LEN);

  logic [1:0]          state_q, state_d;
  logic [CNT_BIT-1:0]  len_q, len_d;
  logic [CNT_BIT-1:0]  beat_q, beat_d;
  logic [ADDR_BIT-1:0] addr_ptr_q;
  logic [CNT_BIT-1:0]  cnt_eff;
  logic                load;
  logic                handshake;
  logic                final_beat;

`ifdef BURST_READER_FLUSH_EN
  localparam int unsigned TO_BIT = $clog2(TIMEOUT + 1);
  localparam logic [TO_BIT-1:0] TO_MAX = TO_BIT'(TIMEOUT);
  logic [TO_BIT-1:0] timeout_q, timeout_d;
`endif

  // A full FIFO reports count 0 while not empty.
  assign cnt_eff    = (fifo_cnt == '0 && !fifo_empty) ? FULL_CNT : {1'b0, fifo_cnt};
  assign handshake  = cache_valid && cache_ready;
  assign final_beat = (beat_q == len_q - 1'b1);
  assign load       = (state_q == ST_BURST) && (beat_q < len_q) && !fifo_empty &&
                      (!cache_valid || cache_ready);
  assign fifo_rd_en = load;
  assign busy       = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    beat_d  = beat_q;
`ifdef BURST_READER_FLUSH_EN
    timeout_d = timeout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cnt_eff >= BURST_CNT) begin
          state_d = ST_BURST;
          len_d   = BURST_CNT;
          beat_d  = '0;
`ifdef BURST_READER_FLUSH_EN
          timeout_d = '0;
        end else if (fifo_empty) begin
          timeout_d = '0;
        end else if (timeout_q == TO_MAX) begin
          // Only this block pops, so cnt_eff words are guaranteed to be present.
          state_d   = ST_BURST;
          len_d     = cnt_eff;
          beat_d    = '0;
          timeout_d = '0;
        end else begin
          timeout_d = timeout_q + 1'b1;
`endif
        end
      end
      ST_BURST: begin
        if (load) begin
          beat_d = beat_q + 1'b1;
          if (final_beat) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (handshake && cache_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      beat_q      <= '0;
      addr_ptr_q  <= '0;
      cache_valid <= 1'b0;
      cache_data  <= '0;
      cache_addr  <= '0;
      cache_last  <= 1'b0;
      burst_done  <= 1'b0;
`ifdef BURST_READER_FLUSH_EN
      timeout_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      burst_done <= (state_q == ST_DRAIN) && handshake && cache_last;
`ifdef BURST_READER_FLUSH_EN
      timeout_q  <= timeout_d;
`endif
      if (load) begin
        cache_valid <= 1'b1;
        cache_data  <= fifo_data;
        cache_addr  <= addr_ptr_q;
        cache_last  <= final_beat;
        addr_ptr_q  <= addr_ptr_q + 1'b1;
      end else if (handshake) begin
        cache_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader with a behavioural show-ahead FIFO model.
// Define BURST_READER_FLUSH_EN for both bench and RTL to exercise the partial flush.
module tb_fifo_burst_reader;

  localparam int DW = 16;
  localparam int DD = 4;
  localparam int BL = 4;
  localparam int AW = 4;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] fifo_data;
  logic          fifo_empty;
  logic [DD-1:0] fifo_cnt;
  logic          fifo_rd_en;
  logic          cache_valid;
  logic          cache_ready;
  logic [DW-1:0] cache_data;
  logic [AW-1:0] cache_addr;
  logic          cache_last;
  logic          burst_done;
  logic          busy;

  fifo_burst_reader #(
    .DATA_BIT  (DW),
    .DATA_DEPTH(DD),
    .BURST_LEN (BL),
    .ADDR_BIT  (AW),
    .TIMEOUT   (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_cnt   (fifo_cnt),
    .fifo_rd_en (fifo_rd_en),
    .cache_valid(cache_valid),
    .cache_ready(cache_ready),
    .cache_data (cache_data),
    .cache_addr (cache_addr),
    .cache_last (cache_last),
    .burst_done (burst_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Show-ahead FIFO model; ever-increasing pointers, unaffected by rst.
  logic [DW-1:0] mem [0:63];
  int unsigned   wr_ptr = 0;
  int unsigned   rd_ptr = 0;
  int unsigned   occ;
  int unsigned   cyc = 0;

  assign occ        = wr_ptr - rd_ptr;
  assign fifo_empty = (occ == 0);
  assign fifo_cnt   = occ[DD-1:0];
  assign fifo_data  = mem[rd_ptr[5:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en) rd_ptr <= rd_ptr + 1;
  end

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    hs_cyc [0:63];
  int    hs_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    mem[wr_ptr[5:0]] = d;
    wr_ptr++;
  endtask

  task automatic expect_beat(input logic [DW-1:0] d, input int a, input logic l);
    beat_t b;
    b.data = d;
    b.addr = AW'(a);
    b.last = l;
    exp_q.push_back(b);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(exp_q.size() == 0 && !busy), 32'd1);
    step();
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
    check({tag, "_valid"}, 32'(cache_valid), 32'd0);
    check({tag, "_data"}, 32'(cache_data), 32'd0);
    check({tag, "_addr"}, 32'(cache_addr), 32'd0);
    check({tag, "_last"}, 32'(cache_last), 32'd0);
    check({tag, "_done"}, 32'(burst_done), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on every handshake.
  initial begin
    logic  prev_stall;
    logic  prev_done_exp;
    beat_t prev_beat;
    beat_t cur;
    beat_t e;
    prev_stall    = 1'b0;
    prev_done_exp = 1'b0;
    prev_beat     = '0;
    forever begin
      @(negedge clk);
      cur = {cache_data, cache_addr, cache_last};
      if (rst) begin
        prev_stall    = 1'b0;
        prev_done_exp = 1'b0;
      end else begin
        if (fifo_rd_en) check("rd_en_legal", 32'({fifo_empty, busy}), 32'b01);
        if (cache_valid && !cache_ready) check("stall_no_pop", 32'(fifo_rd_en), 32'd0);
        if (prev_stall) check("stall_hold", 32'(cur), 32'(prev_beat));
        if (prev_done_exp || burst_done) check("burst_done", 32'(burst_done), 32'(prev_done_exp));
        if (cache_valid && cache_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat: got 0x%0h required no beat", cur);
          end else begin
            e = exp_q.pop_front();
            check("beat", 32'(cur), 32'(e));
          end
          if (hs_total < 64) hs_cyc[hs_total] = cyc;
          hs_total++;
        end
        prev_stall    = cache_valid && !cache_ready;
        prev_beat     = cur;
        prev_done_exp = cache_valid && cache_ready && cache_last;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int found;
    rst         = 1'b1;
    cache_ready = 1'b1;
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Full burst at 1 beat/cycle.
    base = hs_total;
    for (int i = 0; i < 4; i++) begin
      push_word(DW'(16'h00A0 + i));
      expect_beat(DW'(16'h00A0 + i), i, i == 3);
    end
    wait_drain(40, "t1_drain");
    check("t1_back_to_back", 32'(hs_cyc[base + 3] - hs_cyc[base]), 32'd3);

    // Backpressure mid-burst.
    for (int i = 0; i < 4; i++) begin
      push_word(DW'(16'h00B0 + i));
      expect_beat(DW'(16'h00B0 + i), 4 + i, i == 3);
    end
    found = 0;
    for (int n = 0; n < 40 && found == 0; n++) begin
      step();
      if (cache_valid && cache_addr == AW'(5)) found = 1;
    end
    check("bp_reach", 32'(found), 32'd1);
    cache_ready = 1'b0;
    repeat (5) step();
    check("bp_hold_addr", 32'(cache_addr), 32'd5);
    check("bp_hold_data", 32'(cache_data), 32'h00B1);
    cache_ready = 1'b1;
    wait_drain(40, "t2_drain");

    // Full FIFO (count wraps to 0); addresses 8..15 then wrap 0..7.
    for (int i = 0; i < 16; i++) begin
      push_word(DW'(16'h0E00 + i));
      expect_beat(DW'(16'h0E00 + i), (8 + i) % 16, (i % 4) == 3);
    end
    check("t3_cnt_wrapped", 32'(fifo_cnt), 32'd0);
    wait_drain(200, "t3_drain");

    // Reset after two accepted beats; the held third beat is dropped.
    cache_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(DW'(16'h00C0 + i));
    expect_beat(16'h00C0, 8, 1'b0);
    expect_beat(16'h00C1, 9, 1'b0);
    repeat (5) step();
    check("t4_pre_valid", 32'(cache_valid), 32'd1);
    cache_ready = 1'b1;
    step();
    step();
    cache_ready = 1'b0;
    rst         = 1'b1;
    step();
    check_reset_outputs("midrst");
    check("t4_fifo_left", 32'(occ), 32'd1);
    rst         = 1'b0;
    cache_ready = 1'b1;
    expect_beat(16'h00C3, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      push_word(DW'(16'h00D0 + i));
      expect_beat(DW'(16'h00D0 + i), 1 + i, i == 2);
    end
    wait_drain(40, "t4_drain");

    // Residual words below a full burst.
`ifdef BURST_READER_FLUSH_EN
    for (int i = 0; i < 3; i++) begin
      push_word(DW'(16'h00F0 + i));
      expect_beat(DW'(16'h00F0 + i), 4 + i, i == 2);
    end
    wait_drain(80, "flush_drain");
`else
    base = hs_total;
    for (int i = 0; i < 3; i++) push_word(DW'(16'h00F0 + i));
    repeat (40) step();
    check("no_flush_beats", 32'(hs_total - base), 32'd0);
    check("no_flush_busy", 32'(busy), 32'd0);
    check("no_flush_left", 32'(occ), 32'd3);
`endif

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
